// File: rtl/bayer_pkg.sv
// ---------------------------------------------------------------------------
// bayer_pkg
// Shared definitions for the Bayer line-buffer slice.
//   clog2      : ceiling log2, usable in constant expressions (port widths)
//   DATA_W_DEF : default pixel width
//   TAP_*      : tap indices inside out_taps (0 = current line, 1 = line
//                above, 2 = two lines above)
// ---------------------------------------------------------------------------
package bayer_pkg;

   localparam int DATA_W_DEF = 8;

   localparam int TAP_CUR = 0;
   localparam int TAP_UP1 = 1;
   localparam int TAP_UP2 = 2;

   // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage : bayer_pkg

// File: rtl/line_ram_sdp.sv
// ---------------------------------------------------------------------------
// line_ram_sdp
// Simple dual-port line RAM, one clock, registered read.
//   clk_r   : clock, rising edge
//   rst_n   : async active-low reset, clears only the read register
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   re      : read enable; rd_data holds when low
//   raddr   : read address
//   rd_data : registered read data; on a same-address write it returns the
//             contents from before that write
// ---------------------------------------------------------------------------
module line_ram_sdp
   import bayer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 640
) (
   input  logic                      clk_r,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      re,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]         rd_data
);

   // Storage is intentionally not reset so it maps onto block RAM.
   logic [DATA_W-1:0] mem_r [DEPTH];

   // Array write port.
   always_ff @(posedge clk_r) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; sampling before the write lands gives old data.
   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= {DATA_W{1'b0}};
      end else if (re) begin
         rd_data <= mem_r[raddr];
      end else begin
         rd_data <= rd_data;
      end
   end

endmodule : line_ram_sdp

// File: rtl/bayer_line_buffer.sv
// ---------------------------------------------------------------------------
// bayer_line_buffer
// Multi-line buffer feeding the demosaic window. For every accepted pixel it
// emits, one clock later, a vertical column of NUM_LINES pixels: the current
// pixel plus the co-located pixels of the previous NUM_LINES-1 lines, which
// live in NUM_LINES-1 rotating line RAM banks.
//   clk_r       : clock, rising edge
//   rst_n       : async active-low reset
//   sof         : start of frame, qualified by in_valid (pixel 0,0)
//   in_valid    : input pixel strobe, gaps allowed
//   in_data     : input pixel
//   out_valid   : output column strobe
//   out_taps    : tap k at [k*DATA_W +: DATA_W], k=0 current line
//   out_col     : column of out_taps
//   out_row     : row of tap 0, saturating
//   out_rows_ok : out_row >= NUM_LINES-1, every tap holds frame data
//   out_eol     : last column of a line, only with out_valid
// ---------------------------------------------------------------------------
module bayer_line_buffer
   import bayer_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int LINE_W    = 640,
   parameter int NUM_LINES = 3,
   parameter int ROW_W     = 11
) (
   input  logic                          clk_r,
   input  logic                          rst_n,
   input  logic                          sof,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          out_valid,
   output logic [NUM_LINES*DATA_W-1:0]   out_taps,
   output logic [clog2(LINE_W)-1:0]      out_col,
   output logic [ROW_W-1:0]              out_row,
   output logic                          out_rows_ok,
   output logic                          out_eol
);

   localparam int COL_W  = clog2(LINE_W);
   localparam int BANKS  = NUM_LINES - 1;
   localparam int BANK_W = (clog2(BANKS) < 1) ? 1 : clog2(BANKS);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_W - 1);
   localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANKS - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX   = {ROW_W{1'b1}};
   localparam logic [ROW_W-1:0]  ROW_FULL  = ROW_W'(NUM_LINES - 1);

   // Running position of the next pixel.
   logic [COL_W-1:0]  col_r;
   logic [ROW_W-1:0]  row_r;
   logic [BANK_W-1:0] bank_r;

   // Position actually used by the current pixel (sof overrides counters).
   logic [COL_W-1:0]  col_s;
   logic [ROW_W-1:0]  row_s;
   logic [BANK_W-1:0] bank_s;

   // Per-pixel state captured alongside the RAM read.
   logic [DATA_W-1:0] tap0_r;
   logic [BANK_W-1:0] pix_bank_r;

   logic [DATA_W-1:0]           rd_data_s [BANKS];
   logic [BANKS-1:0]            we_s;
   logic [BANK_W-1:0]           sel_s;
   logic [NUM_LINES*DATA_W-1:0] taps_s;

   // Effective pixel position: sof forces (0,0) and bank 0, even mid-line.
   always_comb begin
      col_s  = col_r;
      row_s  = row_r;
      bank_s = bank_r;
      if (sof) begin
         col_s  = {COL_W{1'b0}};
         row_s  = {ROW_W{1'b0}};
         bank_s = {BANK_W{1'b0}};
      end else begin
         col_s  = col_r;
         row_s  = row_r;
         bank_s = bank_r;
      end
   end

   // Column / row / bank counters advance only on accepted pixels.
   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         col_r  <= {COL_W{1'b0}};
         row_r  <= {ROW_W{1'b0}};
         bank_r <= {BANK_W{1'b0}};
      end else if (in_valid) begin
         if (col_s == COL_LAST) begin
            col_r  <= {COL_W{1'b0}};
            row_r  <= (row_s == ROW_MAX) ? row_s : row_s + ROW_W'(1);
            bank_r <= (bank_s == BANK_LAST) ? {BANK_W{1'b0}} : bank_s + BANK_W'(1);
         end else begin
            col_r  <= col_s + COL_W'(1);
            row_r  <= row_s;
            bank_r <= bank_s;
         end
      end else begin
         col_r  <= col_r;
         row_r  <= row_r;
         bank_r <= bank_r;
      end
   end

   // Output registers, aligned with the one-cycle RAM read.
   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_eol     <= 1'b0;
         out_col     <= {COL_W{1'b0}};
         out_row     <= {ROW_W{1'b0}};
         out_rows_ok <= 1'b0;
         tap0_r      <= {DATA_W{1'b0}};
         pix_bank_r  <= {BANK_W{1'b0}};
      end else begin
         out_valid <= in_valid;
         out_eol   <= in_valid & (col_s == COL_LAST);
         if (in_valid) begin
            tap0_r      <= in_data;
            out_col     <= col_s;
            out_row     <= row_s;
            out_rows_ok <= (row_s >= ROW_FULL);
            pix_bank_r  <= bank_s;
         end else begin
            tap0_r      <= tap0_r;
            out_col     <= out_col;
            out_row     <= out_row;
            out_rows_ok <= out_rows_ok;
            pix_bank_r  <= pix_bank_r;
         end
      end
   end

   // One line RAM per stored line; all banks read every pixel, one written.
   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      assign we_s[b] = in_valid & (bank_s == BANK_W'(b));

      line_ram_sdp #(
         .DATA_W (DATA_W),
         .DEPTH  (LINE_W)
      ) u_ram (
         .clk_r   (clk_r),
         .rst_n   (rst_n),
         .we      (we_s[b]),
         .waddr   (col_s),
         .wdata   (in_data),
         .re      (in_valid),
         .raddr   (col_s),
         .rd_data (rd_data_s[b])
      );
   end

   // Tap k is the bank written k lines ago; masked while that bank still
   // holds data from a previous frame or from power-up.
   always_comb begin
      taps_s = {(NUM_LINES*DATA_W){1'b0}};
      sel_s  = {BANK_W{1'b0}};
      taps_s[TAP_CUR*DATA_W +: DATA_W] = tap0_r;
      for (int k = TAP_UP1; k < NUM_LINES; k++) begin
         sel_s = BANK_W'((int'(pix_bank_r) + BANKS - (k % BANKS)) % BANKS);
         if (out_row >= ROW_W'(k)) begin
            taps_s[k*DATA_W +: DATA_W] = rd_data_s[sel_s];
         end else begin
            taps_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
         end
      end
   end

   assign out_taps = taps_s;

endmodule : bayer_line_buffer

// File: tb/tb_bayer_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_bayer_line_buffer
// Directed bench for bayer_line_buffer with LINE_W=4, NUM_LINES=3, DATA_W=8.
// Pixel value = base + row*16 + col; expected taps are the same pixel
// formula applied to the rows above, zero where the row does not exist yet.
// ---------------------------------------------------------------------------
module tb_bayer_line_buffer;

   localparam int DATA_W    = 8;
   localparam int LINE_W    = 4;
   localparam int NUM_LINES = 3;
   localparam int ROW_W     = 11;

   logic        clk_r = 1'b0;
   logic        rst_n;
   logic        sof;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_valid;
   logic [23:0] out_taps;
   logic [1:0]  out_col;
   logic [10:0] out_row;
   logic        out_rows_ok;
   logic        out_eol;

   int          n_cmp = 0;
   int          n_err = 0;
   int          valid_cnt = 0;
   logic [23:0] last_taps = 24'h0;
   logic [23:0] got_taps [4][4];

   bayer_line_buffer #(
      .DATA_W    (DATA_W),
      .LINE_W    (LINE_W),
      .NUM_LINES (NUM_LINES),
      .ROW_W     (ROW_W)
   ) dut (
      .clk_r       (clk_r),
      .rst_n       (rst_n),
      .sof         (sof),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_taps    (out_taps),
      .out_col     (out_col),
      .out_row     (out_row),
      .out_rows_ok (out_rows_ok),
      .out_eol     (out_eol)
   );

   // Free-running clock.
   always #5 clk_r = ~clk_r;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int base, input int r, input int c);
      return 8'(base + r*16 + c);
   endfunction

   function automatic logic [23:0] exp_taps(input int base, input int r, input int c);
      logic [7:0] t1;
      logic [7:0] t2;
      t1 = (r >= 1) ? pix(base, r-1, c) : 8'h00;
      t2 = (r >= 2) ? pix(base, r-2, c) : 8'h00;
      return {t2, t1, pix(base, r, c)};
   endfunction

   // One clock: drive on the falling edge, sample 1 time unit after rising.
   task automatic drive(input logic s, input logic v, input logic [7:0] d);
      @(negedge clk_r);
      sof      = s;
      in_valid = v;
      in_data  = d;
      @(posedge clk_r);
      #1;
      if (out_valid) valid_cnt++;
   endtask

   task automatic idle_check(input string tag);
      drive(1'b0, 1'b0, 8'h00);
      check_eq({tag, " gap valid"}, 32'(out_valid), 32'h0);
      check_eq({tag, " gap taps"},  32'(out_taps),  32'(last_taps));
      check_eq({tag, " gap eol"},   32'(out_eol),   32'h0);
   endtask

   task automatic send_pix(input int base, input int r, input int c, input logic s);
      string t;
      t = $sformatf("b%0h r%0d c%0d", base, r, c);
      drive(s, 1'b1, pix(base, r, c));
      check_eq({t, " valid"},   32'(out_valid),   32'h1);
      check_eq({t, " taps"},    32'(out_taps),    32'(exp_taps(base, r, c)));
      check_eq({t, " col"},     32'(out_col),     32'(c));
      check_eq({t, " row"},     32'(out_row),     32'(r));
      check_eq({t, " rows_ok"}, 32'(out_rows_ok), (r >= 2) ? 32'h1 : 32'h0);
      check_eq({t, " eol"},     32'(out_eol),     (c == 3) ? 32'h1 : 32'h0);
      got_taps[r][c] = out_taps;
      last_taps      = exp_taps(base, r, c);
   endtask

   task automatic send_frame(input int base, input int gap_row);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r == gap_row) begin
               for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                  idle_check($sformatf("r%0d c%0d", r, c));
               end
            end
            send_pix(base, r, c, (r == 0 && c == 0) ? 1'b1 : 1'b0);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, " valid"},   32'(out_valid),   32'h0);
      check_eq({tag, " taps"},    32'(out_taps),    32'h0);
      check_eq({tag, " col"},     32'(out_col),     32'h0);
      check_eq({tag, " row"},     32'(out_row),     32'h0);
      check_eq({tag, " rows_ok"}, 32'(out_rows_ok), 32'h0);
      check_eq({tag, " eol"},     32'(out_eol),     32'h0);
   endtask

   initial begin
      rst_n    = 1'b0;
      sof      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      check_all_zero("reset");
      @(negedge clk_r);
      rst_n = 1'b1;

      // First pixel after reset, then an asynchronous reset mid-line.
      send_pix(0, 0, 0, 1'b1);
      send_pix(0, 0, 1, 1'b0);
      send_pix(0, 0, 2, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_all_zero("async rst");
      @(negedge clk_r);
      rst_n = 1'b1;

      // Gap-free frame fill.
      valid_cnt = 0;
      send_frame(0, -1);
      check_eq("fill count",   32'(valid_cnt),      32'd16);
      check_eq("fill r0c1",    32'(got_taps[0][1]), 32'h000001);
      check_eq("fill r1c1",    32'(got_taps[1][1]), 32'h000111);
      check_eq("fill r2c2",    32'(got_taps[2][2]), 32'h021222);
      check_eq("fill r3c3",    32'(got_taps[3][3]), 32'h132333);

      // Same frame with idle cycles sprinkled through row 2.
      valid_cnt = 0;
      send_frame(0, 2);
      check_eq("gap count",    32'(valid_cnt),      32'd16);
      check_eq("gap r2c2",     32'(got_taps[2][2]), 32'h021222);

      // Mid-line sof truncates the current line and restarts at (0,0).
      for (int c = 0; c < 4; c++) send_pix(0, 0, c, (c == 0) ? 1'b1 : 1'b0);
      send_pix(0, 1, 0, 1'b0);
      send_pix(0, 1, 1, 1'b0);
      send_pix(8'hA0, 0, 0, 1'b1);
      check_eq("midsof taps",  32'(out_taps), 32'h0000A0);
      for (int c = 1; c < 4; c++) send_pix(8'hA0, 0, c, 1'b0);
      for (int c = 0; c < 4; c++) send_pix(8'hA0, 1, c, 1'b0);
      check_eq("midsof r1c2",  32'(got_taps[1][2]), 32'h00A2B2);

      // Back-to-back frames, no bubble between A and B.
      valid_cnt = 0;
      send_frame(0, -1);
      send_frame(8'h80, -1);
      check_eq("b2b count",    32'(valid_cnt),      32'd32);
      check_eq("b2b r0c1",     32'(got_taps[0][1]), 32'h000081);
      check_eq("b2b r2c0",     32'(got_taps[2][0]), 32'h8090A0);
      idle_check("tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_bayer_line_buffer
